// File: rtl/core_fetch_queue.sv
// Instruction queue between fetch (s1) and decode (s2): DEPTH-entry circular buffer of
// {pc, instr, illegal} words with one-cycle branch flush and registered-only status outputs.
module core_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [XLEN-1:0]            i_push_pc,
  input  logic [XLEN-1:0]            i_push_instr,
  input  logic                       i_push_illegal,
  output logic                       o_pop_valid,
  input  logic                       i_pop_ready,
  output logic [XLEN-1:0]            o_pop_pc,
  output logic [XLEN-1:0]            o_pop_instr,
  output logic                       o_pop_illegal,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef struct packed {
    logic            illegal;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_fire;
  logic          pop_fire;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  // Status is decoded from the count register only, so ready never depends on i_pop_ready.
  assign o_empty      = (count == '0);
  assign o_full       = (count == FULL_CNT);
  assign o_push_ready = !o_full;
  assign o_pop_valid  = !o_empty;
  assign o_count      = count;

  assign push_fire = i_push_valid && o_push_ready && !i_flush;
  assign pop_fire  = o_pop_valid  && i_pop_ready  && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= next_slot(wr_ptr);
      if (pop_fire)  rd_ptr <= next_slot(rd_ptr);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale slot contents are never observed.
  always_ff @(posedge i_clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= '{illegal: i_push_illegal, instr: i_push_instr, pc: i_push_pc};
    end
  end

  assign head          = mem[rd_ptr];
  assign o_pop_pc      = head.pc;
  assign o_pop_instr   = head.instr;
  assign o_pop_illegal = head.illegal;

endmodule

// File: tb/tb_core_fetch_queue.sv
// Bench for core_fetch_queue: DEPTH=4 and DEPTH=3 instances share stimulus and are each
// compared every cycle against an in-order list model, plus directed literal checks.
module tb_core_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, push_valid, pop_ready, push_ill;
  logic [31:0] push_pc, push_instr;

  logic [1:0]       push_ready_v, pop_valid_v, pop_ill_v, empty_v, full_v;
  logic [1:0][31:0] pop_pc_v, pop_instr_v;
  logic [1:0][2:0]  count_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int D = (k == 0) ? 4 : 3;
    logic [$clog2(D+1)-1:0] cnt;
    core_fetch_queue #(.DEPTH(D), .XLEN(32)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_flush        (flush),
      .i_push_valid   (push_valid),
      .o_push_ready   (push_ready_v[k]),
      .i_push_pc      (push_pc),
      .i_push_instr   (push_instr),
      .i_push_illegal (push_ill),
      .o_pop_valid    (pop_valid_v[k]),
      .i_pop_ready    (pop_ready),
      .o_pop_pc       (pop_pc_v[k]),
      .o_pop_instr    (pop_instr_v[k]),
      .o_pop_illegal  (pop_ill_v[k]),
      .o_count        (cnt),
      .o_empty        (empty_v[k]),
      .o_full         (full_v[k])
    );
    assign count_v[k] = 3'(cnt);
  end

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list per instance, head at index 0.
  ent_t mlist [2][8];
  int   msize [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msize[0] <= 0;
      msize[1] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ent_t nxt [8];
        int   sz;
        bit   do_pop, do_push;
        for (int i = 0; i < 8; i++) nxt[i] = mlist[k][i];
        sz = msize[k];
        if (flush) begin
          sz = 0;
        end else begin
          do_pop  = (sz > 0) && pop_ready;
          do_push = push_valid && (sz < dep(k));
          if (do_pop) begin
            for (int i = 0; i < 7; i++) nxt[i] = nxt[i+1];
            sz--;
          end
          if (do_push) begin
            nxt[sz] = '{pc: push_pc, instr: push_instr, ill: push_ill};
            sz++;
          end
        end
        for (int i = 0; i < 8; i++) mlist[k][i] <= nxt[i];
        msize[k] <= sz;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d_count", k), count_v[k], msize[k]);
      check($sformatf("d%0d_empty", k), empty_v[k], msize[k] == 0);
      check($sformatf("d%0d_full", k), full_v[k], msize[k] == dep(k));
      check($sformatf("d%0d_push_ready", k), push_ready_v[k], msize[k] != dep(k));
      check($sformatf("d%0d_pop_valid", k), pop_valid_v[k], msize[k] != 0);
      if (msize[k] > 0) begin
        check($sformatf("d%0d_pop_pc", k), pop_pc_v[k], mlist[k][0].pc);
        check($sformatf("d%0d_pop_instr", k), pop_instr_v[k], mlist[k][0].instr);
        check($sformatf("d%0d_pop_ill", k), pop_ill_v[k], mlist[k][0].ill);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    push_ill   = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic ill);
    push_valid = 1'b1;
    push_pc    = pc;
    push_instr = $urandom;
    push_ill   = ill;
    step();
    push_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    pop_ready = 1'b1;
    repeat (n) step();
    pop_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    push_pc = '0;
    push_instr = '0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_count", count_v[0], 0);
    check("reset_push_ready", push_ready_v[0], 1);
    step();

    // Fill and drain: DEPTH=4 accepts 4 then refuses 0x10.
    for (int i = 0; i < 4; i++) push_one(32'(i * 4), 1'b0);
    push_valid = 1'b1;
    push_pc    = 32'h10;
    @(negedge clk);
    check("fill_count", count_v[0], 4);
    check("fill_full", full_v[0], 1);
    check("fill_ready", push_ready_v[0], 0);
    step();
    push_valid = 1'b0;
    @(negedge clk);
    check("fill_no_5th", count_v[0], 4);
    step();
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_order", pop_pc_v[0], 32'(i * 4));
      step();
    end
    pop_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", empty_v[0], 1);
    step();

    // Wrap with occupancy held at 2 on both depths.
    push_one(32'h500, 1'b0);
    push_one(32'h504, 1'b0);
    push_valid = 1'b1;
    pop_ready  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_pc    = 32'h500 + 32'(4 * (i + 2));
      push_instr = $urandom;
      @(negedge clk);
      check("wrap_count4", count_v[0], 2);
      check("wrap_count3", count_v[1], 2);
      check("wrap_pc4", pop_pc_v[0], 32'h500 + 32'(4 * i));
      check("wrap_pc3", pop_pc_v[1], 32'h500 + 32'(4 * i));
      step();
    end
    drain(3);

    // Asynchronous reset with 3 entries queued.
    for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(4 * i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count_v[0], 0);
    check("arst_pop_valid", pop_valid_v[0], 0);
    check("arst_push_ready", push_ready_v[0], 1);
    step();
    step();
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    check("arst_no_stale", empty_v[0], 1);
    step();

    // Flush wins over a concurrent push and pop.
    for (int i = 0; i < 3; i++) push_one(32'h20 + 32'(4 * i), 1'b0);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_pc    = 32'h40;
    pop_ready  = 1'b1;
    step();
    idle();
    @(negedge clk);
    check("flush_count", count_v[0], 0);
    check("flush_pop_valid", pop_valid_v[0], 0);
    step();
    push_one(32'h80, 1'b0);
    @(negedge clk);
    check("flush_next_pc", pop_pc_v[0], 32'h80);
    step();
    drain(1);

    // Illegal tag travels with its entry.
    push_one(32'h100, 1'b1);
    push_one(32'h104, 1'b0);
    @(negedge clk);
    check("ill_first", {pop_pc_v[0], 31'b0, pop_ill_v[0]}, {32'h100, 32'h1});
    step();
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    @(negedge clk);
    check("ill_second", {pop_pc_v[0], 31'b0, pop_ill_v[0]}, {32'h104, 32'h0});
    step();
    drain(1);

    // Backpressure: head holds while pushes fill the queue.
    push_valid = 1'b1;
    push_pc    = 32'h200;
    push_instr = 32'hdead_0200;
    push_ill   = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      automatic int exp_cnt = (1 + i < 4) ? 1 + i : 4;
      push_pc    = 32'h204 + 32'(4 * i);
      push_instr = $urandom;
      @(negedge clk);
      check("bp_pc", pop_pc_v[0], 32'h200);
      check("bp_instr", pop_instr_v[0], 32'hdead_0200);
      check("bp_count", count_v[0], exp_cnt);
      check("bp_ready", push_ready_v[0], exp_cnt < 4);
      step();
    end
    drain(5);

    // Random traffic with occasional flush and reset pulses.
    for (int n = 0; n < 3000; n++) begin
      push_valid = ($urandom % 4) != 0;
      pop_ready  = ($urandom % 3) != 0;
      flush      = ($urandom % 40) == 0;
      push_pc    = $urandom;
      push_instr = $urandom;
      push_ill   = 1'($urandom % 2);
      if (($urandom % 300) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end
    idle();
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
